rr_bus_arbiter: RTL and testbench
=================================

Name: rr_bus_arbiter

Overview:
Round-robin arbiter that shares the single-master system bus among 8 requesters (register file, ALU, memory, I/O, ...). It holds the winner as a 3-bit index plus enable and drives a decoder3to8enable instance to produce the one-hot bus-drive select. It sits between the requester handshake lines and the bus tri-state/mux select in the simple computer datapath.

Parameters:
MAX_HOLD, 15, maximum consecutive OWN cycles for one grant before forced release (1..255)
HOLD_W, 8, width of the hold counter; must hold MAX_HOLD

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  8  request lines, bit i = requester i; level, held until served
release  input  1  current owner done; sampled only in OWN
grant_idx  output  3  index of current/last owner
grant_en  output  1  bus granted (registered)
grant_onehot  output  8  decoder3to8enable(enable=grant_en, ins=grant_idx) output
busy  output  1  high in OWN state
timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD

Behaviour:
- Reset (async, active-high): state=IDLE, grant_idx=3'b111 (so requester 0 has first priority), grant_en=0, grant_onehot=8'h00, busy=0, timeout=0, hold count=0.
- States: IDLE, OWN. All outputs except grant_onehot are registered; grant_onehot is combinational from registered grant_en/grant_idx.
- IDLE: if req!=0, pick first set bit scanning (grant_idx+1) mod 8 upward with wrap; next edge: grant_idx<=winner, grant_en<=1, busy<=1, hold<=0, state<=OWN. If req==0, stay; grant_idx unchanged.
- Latency: req rising at edge N (IDLE) -> grant_en high after edge N+1.
- OWN: hold increments each cycle. Exit to IDLE on the first edge where any is true: release=1; req[grant_idx]=0 (owner dropped); hold==MAX_HOLD-1 (timeout). On exit grant_en<=0, busy<=0, grant_idx kept (round-robin pointer).
- Timeout exit also sets timeout=1 for exactly that one cycle; release/drop on the same edge takes precedence (timeout stays 0).
- Turnaround: every exit gives >=1 cycle with grant_en=0 before the next grant (no back-to-back overlap on the bus).
- Fairness: the releasing owner has lowest priority next round; a single persistent requester is re-granted after one idle cycle.
- req changes from non-owners during OWN are ignored until IDLE.
- release in IDLE is ignored.
- Reset mid-OWN: immediate return to reset values; grant_onehot goes 8'h00 without waiting for clk.
- hold counter never wraps; MAX_HOLD=1 gives exactly 1 OWN cycle per grant.

Optional Feature:
ARB_TIMEOUT_EN. Defined: MAX_HOLD limit enforced, timeout port pulses as above. Not defined: no hold counter; owner keeps bus until release or drop; timeout tied to 0; MAX_HOLD/HOLD_W unused.

Test Plan:
- Reset with req=8'hFF, then deassert reset -> after 1 edge grant_idx=0, grant_onehot=8'h01, busy=1; assert reset async mid-OWN -> grant_onehot=8'h00 before next edge.
- req=8'h24 held, release pulsed 1 cycle after each grant -> grants alternate 2,5,2,5 with one grant_en=0 cycle between each.
- req=8'h80 only, owner releases -> grant_idx=7, then after idle cycle grant_idx=7 again (wrap scan 0..7 finds 7).
- ARB_TIMEOUT_EN, MAX_HOLD=15, req=8'h03, no release -> requester 0 owns exactly 15 cycles, timeout=1 on exit cycle, next grant_idx=1.
- Owner 3 drops req[3] in OWN while req[4]=1 -> grant_en falls next edge, timeout=0, then grant_idx=4.
- Without ARB_TIMEOUT_EN, req=8'h01 held 100 cycles with no release -> grant_en stays 1 all 100 cycles, timeout never 1.

Source files
------------

// File: rtl/rr_bus_arbiter_if.sv
// Handshake bundle between the bus requesters and the round-robin arbiter.
// Named bus_release because release is a reserved word in SystemVerilog.
interface rr_bus_arbiter_if;
    logic [7:0] req;
    logic       bus_release;
    logic [2:0] grant_idx;
    logic       grant_en;
    logic [7:0] grant_onehot;
    logic       busy;
    logic       timeout;

    // arbiter side drives the grant outputs
    modport master (
        input  req, bus_release,
        output grant_idx, grant_en, grant_onehot, busy, timeout
    );

    // requester side drives req/bus_release and observes the grant
    modport slave (
        output req, bus_release,
        input  grant_idx, grant_en, grant_onehot, busy, timeout
    );
endinterface

// File: rtl/rr_bus_arbiter.sv
// Round-robin 8-way system bus arbiter with one-hot bus-drive select.
// Optional ARB_TIMEOUT_EN: enforces a MAX_HOLD cycle limit per grant and pulses timeout.

// Purpose: 3-to-8 decoder with enable, used for the bus-drive select.
// Latency: combinational.
// Backpressure: none.
module decoder3to8enable (
    input  logic       enable,
    input  logic [2:0] ins,
    output logic [7:0] outs
);
    always_comb begin
        outs = 8'h00;
        if (enable) begin
            outs[ins] = 1'b1;
        end
    end
endmodule

// Purpose: grant the shared bus to one of 8 requesters in round-robin order.
// Latency: request seen in IDLE at edge N -> grant_en high after edge N+1.
// Backpressure: owner keeps the bus until release, request drop or hold limit; other requests wait.
module rr_bus_arbiter #(
    parameter int MAX_HOLD = 15,
    parameter int HOLD_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    rr_bus_arbiter_if.master bus
);
    typedef enum logic {IDLE, OWN} state_t;

    state_t     state;
    logic [2:0] grant_idx;
    logic       grant_en;
    logic       busy;
    logic       timeout;
    logic [2:0] winner;
    logic [2:0] cand;
    logic       owner_done;
    logic       hold_last;

    // Scan downward so the candidate closest after the last owner wins;
    // k=8 lands on the last owner itself, giving it lowest priority.
    always_comb begin
        winner = grant_idx;
        cand   = grant_idx;
        for (int k = 8; k >= 1; k--) begin
            cand = grant_idx + 3'(k);
            if (bus.req[cand]) begin
                winner = cand;
            end
        end
    end

    assign owner_done = bus.bus_release || !bus.req[grant_idx];

`ifdef ARB_TIMEOUT_EN
    logic [HOLD_W-1:0] hold;
    assign hold_last = (hold == HOLD_W'(MAX_HOLD - 1));
`else
    wire [HOLD_W-1:0] unused_hold_cfg = HOLD_W'(MAX_HOLD);
    assign hold_last = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant_idx <= 3'b111;
            grant_en  <= 1'b0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold      <= '0;
`endif
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        grant_idx <= winner;
                        grant_en  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= OWN;
`ifdef ARB_TIMEOUT_EN
                        hold      <= '0;
`endif
                    end
                end
                OWN: begin
                    // grant_idx is kept on exit: it is the round-robin pointer
                    if (owner_done || hold_last) begin
                        grant_en <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                        timeout  <= !owner_done && hold_last;
                    end else begin
`ifdef ARB_TIMEOUT_EN
                        hold <= hold + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant_idx = grant_idx;
    assign bus.grant_en  = grant_en;
    assign bus.busy      = busy;
    assign bus.timeout   = timeout;

    decoder3to8enable u_dec (
        .enable (grant_en),
        .ins    (grant_idx),
        .outs   (bus.grant_onehot)
    );
endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed bench for rr_bus_arbiter with an expected-value scoreboard.
module tb_rr_bus_arbiter;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    rr_bus_arbiter_if bus ();

    rr_bus_arbiter #(.MAX_HOLD(15), .HOLD_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic       en;
        logic [2:0] idx;
        logic [7:0] oh;
        logic       busy;
        logic       to;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    passes = 0;
    int    fails  = 0;

    function automatic obs_t model(input bit en, input bit [2:0] idx, input bit to);
        obs_t m;
        m.en   = en;
        m.idx  = idx;
        m.oh   = en ? (8'h01 << idx) : 8'h00;
        m.busy = en;
        m.to   = to;
        return m;
    endfunction

    task automatic push(input string tag, input bit en, input bit [2:0] idx, input bit to);
        exp_q.push_back(model(en, idx, to));
        tag_q.push_back(tag);
    endtask

    task automatic check_out();
        obs_t  o;
        obs_t  e;
        string t;
        o = {bus.grant_en, bus.grant_idx, bus.grant_onehot, bus.busy, bus.timeout};
        checks++;
        if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_empty observed=%h expected=none", o);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (o === e) passes++;
            else begin
                fails++;
                $error("FAIL %s observed=%h expected=%h", t, o, e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic cyc(input string tag, input bit en, input bit [2:0] idx, input bit to);
        push(tag, en, idx, to);
        step();
    endtask

    initial begin
        reset           = 1'b1;
        bus.req         = 8'hFF;
        bus.bus_release = 1'b0;
        #2;
        push("reset_state", 0, 3'd7, 0);
        check_out();

        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc("first_grant_0", 1, 3'd0, 0);

        // asynchronous reset mid-OWN, observed before the next edge
        #3;
        reset = 1'b1;
        #1;
        push("async_reset", 0, 3'd7, 0);
        check_out();
        bus.req = 8'h00;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc("idle_no_req", 0, 3'd7, 0);

        // alternate 2,5,2,5 with one idle cycle between grants
        bus.req = 8'h24;
        for (int r = 0; r < 4; r++) begin
            cyc("rr_grant", 1, (r % 2 == 0) ? 3'd2 : 3'd5, 0);
            bus.bus_release = 1'b1;
            cyc("rr_release", 0, (r % 2 == 0) ? 3'd2 : 3'd5, 0);
            bus.bus_release = 1'b0;
        end

        // single requester 7: re-granted after one idle cycle
        bus.req = 8'h80;
        cyc("wrap_grant_7", 1, 3'd7, 0);
        bus.bus_release = 1'b1;
        cyc("wrap_release", 0, 3'd7, 0);
        bus.bus_release = 1'b0;
        cyc("wrap_regrant_7", 1, 3'd7, 0);
        bus.bus_release = 1'b1;
        cyc("wrap_release2", 0, 3'd7, 0);
        bus.bus_release = 1'b0;

        // owner 3 drops its request while 4 waits
        bus.req = 8'h08;
        cyc("grant_3", 1, 3'd3, 0);
        bus.req = 8'h18;
        cyc("own3_ignores_4", 1, 3'd3, 0);
        bus.req = 8'h10;
        cyc("drop_exit", 0, 3'd3, 0);
        cyc("grant_4", 1, 3'd4, 0);

        // release while idle has no effect
        bus.bus_release = 1'b1;
        cyc("release_4", 0, 3'd4, 0);
        bus.req = 8'h00;
        cyc("idle_release_ignored", 0, 3'd4, 0);
        bus.bus_release = 1'b0;

`ifdef ARB_TIMEOUT_EN
        bus.req = 8'h03;
        cyc("to_grant_0", 1, 3'd0, 0);
        for (int i = 1; i < 15; i++) begin
            cyc("to_own_0", 1, 3'd0, 0);
        end
        cyc("to_exit", 0, 3'd0, 1);
        cyc("to_next_grant_1", 1, 3'd1, 0);
`else
        bus.req = 8'h01;
        cyc("hold_grant_0", 1, 3'd0, 0);
        for (int i = 0; i < 100; i++) begin
            cyc("hold_no_timeout", 1, 3'd0, 0);
        end
        bus.bus_release = 1'b1;
        cyc("hold_release", 0, 3'd0, 0);
        bus.bus_release = 1'b0;
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
